// File: rtl/spi_master_pkg.sv
// Shared types and constants for the SPI frame master slice: FSM state encoding,
// frame geometry and command opcodes carried in the top 8 bits of every frame.
package spi_master_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        SHIFT_LO,
        SHIFT_HI,
        TRAIL,
        GAP
    } state_t;

    localparam int DEFAULT_FRAME_LEN = 136;
    localparam int OPCODE_W          = 8;
    localparam int PAYLOAD_W         = 128;

    localparam logic [OPCODE_W-1:0] OP_DDPUF_EXCITE  = 8'd1;
    localparam logic [OPCODE_W-1:0] OP_XORPUF_EXCITE = 8'd2;
    localparam logic [OPCODE_W-1:0] OP_DDPUF_READ    = 8'd3;
    localparam logic [OPCODE_W-1:0] OP_XORPUF_READ   = 8'd4;
    localparam logic [OPCODE_W-1:0] OP_CHAL_LOAD0    = 8'd5;
    localparam logic [OPCODE_W-1:0] OP_CHAL_LOAD1    = 8'd6;

    function automatic logic [OPCODE_W+PAYLOAD_W-1:0] make_frame(
        input logic [OPCODE_W-1:0]  opcode,
        input logic [PAYLOAD_W-1:0] payload
    );
        return {opcode, payload};
    endfunction

endpackage

// File: rtl/spi_phase_timer.sv
// Half-period down-counter for the SPI frame master. Reloads to CLK_DIV or
// 2*CLK_DIV cycles and pulses phase_end on the last cycle of the loaded phase.
module spi_phase_timer #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic long_phase,
    output logic phase_end
);

    localparam int CW = $clog2(2 * CLK_DIV);
    localparam logic [CW-1:0] LONG_RELOAD  = CW'(2 * CLK_DIV - 1);
    localparam logic [CW-1:0] SHORT_RELOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;
    logic          running;

    // Reload values are one less than the phase length so the widest phase fits the counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            running <= 1'b0;
        end else if (load) begin
            cnt     <= long_phase ? LONG_RELOAD : SHORT_RELOAD;
            running <= 1'b1;
        end else if (running) begin
            if (cnt == '0)
                running <= 1'b0;
            else
                cnt <= cnt - 1'b1;
        end
    end

    assign phase_end = running && (cnt == '0);

endmodule

// File: rtl/spi_frame_master.sv
// Frame-level SPI initiator: shifts one FRAME_LEN-bit command out on MOSI while
// capturing FRAME_LEN bits from MISO. Optional SPI_FRAME_MASTER_LOOPBACK_EN adds a loopback port.
module spi_frame_master
    import spi_master_pkg::*;
#(
    parameter int FRAME_LEN = DEFAULT_FRAME_LEN,
    parameter int CLK_DIV   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [FRAME_LEN-1:0] tx_frame,
    output logic                 busy,
    output logic                 done,
    output logic [FRAME_LEN-1:0] rx_frame,
    output logic                 sclk,
    output logic                 ssel,
    output logic                 mosi,
`ifdef SPI_FRAME_MASTER_LOOPBACK_EN
    input  logic                 loopback,
`endif
    input  logic                 miso
);

    localparam int BW = $clog2(FRAME_LEN + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_LEN);

    state_t               state;
    logic [FRAME_LEN-1:0] tx_shift;
    logic [FRAME_LEN-1:0] rx_shift;
    logic [BW-1:0]        bit_cnt;
    logic                 phase_end;
    logic                 accept;
    logic                 timer_load;
    logic                 timer_long;
    logic                 capture_bit;

    spi_phase_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (timer_load),
        .long_phase (timer_long),
        .phase_end  (phase_end)
    );

    // MOSI is the top of the tx register; clearing that register in GAP returns the pin to 0.
    assign mosi = tx_shift[FRAME_LEN-1];

`ifdef SPI_FRAME_MASTER_LOOPBACK_EN
    assign capture_bit = loopback ? tx_shift[FRAME_LEN-1] : miso;
`else
    assign capture_bit = miso;
`endif

    // A START held through the end of GAP is accepted on that edge, so back-to-back
    // frames are separated by exactly the GAP with no extra idle cycle.
    always_comb begin
        accept     = start && ((state == IDLE) || ((state == GAP) && phase_end));
        timer_load = accept || (phase_end && (state inside {LEAD, SHIFT_LO, SHIFT_HI, TRAIL}));
        timer_long = accept
                   || ((state == SHIFT_HI) && (bit_cnt == LAST_BIT))
                   || (state == TRAIL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tx_shift <= '0;
            rx_shift <= '0;
            rx_frame <= '0;
            bit_cnt  <= '0;
            sclk     <= 1'b0;
            ssel     <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                state    <= LEAD;
                tx_shift <= tx_frame;
                rx_shift <= '0;
                bit_cnt  <= '0;
                sclk     <= 1'b0;
                ssel     <= 1'b0;
                busy     <= 1'b1;
            end else if (phase_end) begin
                case (state)
                    LEAD: state <= SHIFT_LO;
                    SHIFT_LO: begin
                        state    <= SHIFT_HI;
                        sclk     <= 1'b1;
                        rx_shift <= {rx_shift[FRAME_LEN-2:0], capture_bit};
                        bit_cnt  <= bit_cnt + 1'b1;
                    end
                    SHIFT_HI: begin
                        sclk <= 1'b0;
                        if (bit_cnt == LAST_BIT) begin
                            state <= TRAIL;
                        end else begin
                            state    <= SHIFT_LO;
                            tx_shift <= {tx_shift[FRAME_LEN-2:0], 1'b0};
                        end
                    end
                    TRAIL: begin
                        state    <= GAP;
                        ssel     <= 1'b1;
                        done     <= 1'b1;
                        rx_frame <= rx_shift;
                        tx_shift <= '0;
                    end
                    GAP: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_frame_master.sv
// Directed testbench for spi_frame_master (FRAME_LEN=136, CLK_DIV=2) with a MISO slave model;
// the loopback scenario is compiled only when SPI_FRAME_MASTER_LOOPBACK_EN is defined.
module tb_spi_frame_master;
    import spi_master_pkg::*;

    localparam int FL  = 136;
    localparam int DIV = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [FL-1:0] tx_frame = '0;
    logic          miso = 1'b0;
    logic          busy, done, sclk, ssel, mosi;
    logic [FL-1:0] rx_frame;
`ifdef SPI_FRAME_MASTER_LOOPBACK_EN
    logic          loopback = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    logic [FL-1:0] slave_pat = '0;
    int            slave_idx = 0;
    logic [FL-1:0] mosi_log = '0;
    int            rise_cnt = 0;
    int            first_rise_at = -1;
    int            done_cnt = 0;
    int            busy_cycles = 0;

    spi_frame_master #(.FRAME_LEN(FL), .CLK_DIV(DIV)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .tx_frame (tx_frame),
        .busy     (busy),
        .done     (done),
        .rx_frame (rx_frame),
        .sclk     (sclk),
        .ssel     (ssel),
        .mosi     (mosi),
`ifdef SPI_FRAME_MASTER_LOOPBACK_EN
        .loopback (loopback),
`endif
        .miso     (miso)
    );

    always #5 clk = ~clk;

    // Slave model: presents the pattern MSB first, advancing on each SCLK fall.
    always @(negedge ssel) begin
        slave_idx = 0;
        miso = slave_pat[FL-1];
    end
    always @(negedge sclk) begin
        if (!ssel) begin
            slave_idx++;
            miso = (slave_idx < FL) ? slave_pat[FL-1-slave_idx] : 1'b0;
        end
    end

    always @(posedge sclk) begin
        if (rise_cnt == 0) first_rise_at = busy_cycles;
        mosi_log = {mosi_log[FL-2:0], mosi};
        rise_cnt++;
    end

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (busy) busy_cycles++;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_monitors();
        mosi_log = '0;
        rise_cnt = 0;
        first_rise_at = -1;
        done_cnt = 0;
        busy_cycles = 0;
    endtask

    task automatic wait_done(input int budget, output bit seen);
        int base;
        base = done_cnt;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            if (done_cnt != base) seen = 1'b1;
        end
    endtask

    task automatic wait_idle(input int budget, output bit idle);
        idle = !busy;
        for (int i = 0; i < budget && !idle; i++) begin
            step();
            idle = !busy;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++; if (ssel !== 1'b1) begin errors++; $display("[TB] FAIL reset_ssel: got %b expected 1", ssel); end
        checks++; if (sclk !== 1'b0) begin errors++; $display("[TB] FAIL reset_sclk: got %b expected 0", sclk); end
        checks++; if (mosi !== 1'b0) begin errors++; $display("[TB] FAIL reset_mosi: got %b expected 0", mosi); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        checks++; if (rx_frame !== '0) begin errors++; $display("[TB] FAIL reset_rx: got %h expected 0", rx_frame); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        logic [FL-1:0] exp_tx;
        bit seen, idle;
        exp_tx = make_frame(OP_DDPUF_EXCITE, 128'd10);
        slave_pat = '0;
        tx_frame = exp_tx;
        clear_monitors();
        start = 1'b1;
        step();
        start = 1'b0;
        tx_frame = ~exp_tx;
        checks++; if (ssel !== 1'b0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL basic_accept: ssel=%b busy=%b expected ssel=0 busy=1", ssel, busy); end
        wait_done(1200, seen);
        checks++; if (!seen) begin errors++; $display("[TB] FAIL basic_done_timeout: no DONE within 1200 cycles"); end
        checks++; if (busy_cycles !== 2*DIV*(FL+2)+1) begin errors++; $display("[TB] FAIL basic_done_latency: got %0d expected %0d", busy_cycles, 2*DIV*(FL+2)+1); end
        checks++; if (ssel !== 1'b1) begin errors++; $display("[TB] FAIL basic_ssel_at_done: got %b expected 1", ssel); end
        checks++; if (first_rise_at !== 3*DIV) begin errors++; $display("[TB] FAIL basic_first_rise: got %0d expected %0d", first_rise_at, 3*DIV); end
        checks++; if (rise_cnt !== FL) begin errors++; $display("[TB] FAIL basic_rise_count: got %0d expected %0d", rise_cnt, FL); end
        checks++; if (mosi_log !== exp_tx) begin errors++; $display("[TB] FAIL basic_mosi: got %h expected %h", mosi_log, exp_tx); end
        step();
        checks++; if (mosi !== 1'b0) begin errors++; $display("[TB] FAIL basic_mosi_gap: got %b expected 0", mosi); end
        wait_idle(20, idle);
        checks++; if (!idle) begin errors++; $display("[TB] FAIL basic_idle_timeout: BUSY still high"); end
        checks++; if (busy_cycles !== 556) begin errors++; $display("[TB] FAIL basic_busy_len: got %0d expected 556", busy_cycles); end
        checks++; if (done_cnt !== 1) begin errors++; $display("[TB] FAIL basic_done_count: got %0d expected 1", done_cnt); end
        checks++; if (rx_frame !== '0) begin errors++; $display("[TB] FAIL basic_rx_zero: got %h expected 0", rx_frame); end
    endtask

    task automatic test_miso_capture();
        logic [FL-1:0] pat;
        bit seen, idle;
        pat = {8'hC3, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3211};
        slave_pat = pat;
        tx_frame = make_frame(OP_DDPUF_READ, 128'h0);
        clear_monitors();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(1200, seen);
        checks++; if (!seen) begin errors++; $display("[TB] FAIL miso_done_timeout: no DONE within 1200 cycles"); end
        checks++; if (rx_frame !== pat) begin errors++; $display("[TB] FAIL miso_rx: got %h expected %h", rx_frame, pat); end
        wait_idle(20, idle);
    endtask

    task automatic test_start_while_busy();
        bit seen, idle;
        slave_pat = '0;
        tx_frame = make_frame(OP_XORPUF_EXCITE, 128'hFF);
        clear_monitors();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (100) step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(1200, seen);
        wait_idle(20, idle);
        repeat (40) step();
        checks++; if (done_cnt !== 1) begin errors++; $display("[TB] FAIL busy_start_done_count: got %0d expected 1", done_cnt); end
        checks++; if (busy !== 1'b0 || ssel !== 1'b1) begin errors++; $display("[TB] FAIL busy_start_requeued: busy=%b ssel=%b expected 0 1", busy, ssel); end
    endtask

    task automatic test_back_to_back();
        int hi_run, ng;
        int gaps[2];
        bit idle;
        hi_run = 0;
        ng = 0;
        gaps[0] = -1;
        gaps[1] = -1;
        tx_frame = make_frame(OP_CHAL_LOAD0, 128'hA5A5);
        clear_monitors();
        start = 1'b1;
        for (int i = 0; i < 3*600 && done_cnt < 3; i++) begin
            step();
            if (ssel) begin
                hi_run++;
            end else begin
                if (hi_run > 0 && ng < 2) begin
                    gaps[ng] = hi_run;
                    ng++;
                end
                hi_run = 0;
            end
        end
        start = 1'b0;
        wait_idle(20, idle);
        repeat (20) step();
        checks++; if (done_cnt !== 3) begin errors++; $display("[TB] FAIL b2b_done_count: got %0d expected 3", done_cnt); end
        checks++; if (gaps[0] !== 2*DIV) begin errors++; $display("[TB] FAIL b2b_gap0: got %0d expected %0d", gaps[0], 2*DIV); end
        checks++; if (gaps[1] !== 2*DIV) begin errors++; $display("[TB] FAIL b2b_gap1: got %0d expected %0d", gaps[1], 2*DIV); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle: busy got %b expected 0", busy); end
    endtask

    task automatic test_reset_midframe();
        logic [FL-1:0] pat, exp_tx;
        bit seen, idle;
        pat = {8'h5A, 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555};
        exp_tx = make_frame(OP_XORPUF_READ, 128'h1357_9BDF);
        slave_pat = pat;
        tx_frame = exp_tx;
        clear_monitors();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 1000 && rise_cnt < 70; i++) step();
        checks++; if (rise_cnt !== 70) begin errors++; $display("[TB] FAIL midreset_reach_bit70: got %0d rises expected 70", rise_cnt); end
        rst_n = 1'b0;
        #1;
        checks++; if ({ssel, sclk, mosi, busy, done} !== 5'b10000) begin errors++; $display("[TB] FAIL midreset_pins: got ssel,sclk,mosi,busy,done=%b expected 10000", {ssel, sclk, mosi, busy, done}); end
        checks++; if (rx_frame !== '0) begin errors++; $display("[TB] FAIL midreset_rx: got %h expected 0", rx_frame); end
        step();
        step();
        rst_n = 1'b1;
        repeat (50) step();
        checks++; if (done_cnt !== 0) begin errors++; $display("[TB] FAIL midreset_no_done: got %0d expected 0", done_cnt); end
        clear_monitors();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(1200, seen);
        checks++; if (!seen) begin errors++; $display("[TB] FAIL midreset_next_timeout: no DONE within 1200 cycles"); end
        checks++; if (rx_frame !== pat) begin errors++; $display("[TB] FAIL midreset_next_rx: got %h expected %h", rx_frame, pat); end
        checks++; if (mosi_log !== exp_tx) begin errors++; $display("[TB] FAIL midreset_next_mosi: got %h expected %h", mosi_log, exp_tx); end
        wait_idle(20, idle);
    endtask

`ifdef SPI_FRAME_MASTER_LOOPBACK_EN
    task automatic test_loopback();
        logic [FL-1:0] exp_tx;
        bit seen, idle;
        exp_tx = {8'd5, $urandom, $urandom, $urandom, $urandom};
        slave_pat = '1;
        tx_frame = exp_tx;
        loopback = 1'b1;
        clear_monitors();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(1200, seen);
        checks++; if (!seen) begin errors++; $display("[TB] FAIL loopback_timeout: no DONE within 1200 cycles"); end
        checks++; if (rx_frame !== exp_tx) begin errors++; $display("[TB] FAIL loopback_rx: got %h expected %h", rx_frame, exp_tx); end
        wait_idle(20, idle);
        loopback = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_miso_capture();
        test_start_while_busy();
        test_back_to_back();
        test_reset_midframe();
`ifdef SPI_FRAME_MASTER_LOOPBACK_EN
        test_loopback();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
